// File: rtl/bcd_convert_sequencer.sv
// Multi-cycle double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking of the loaded result when BCD_BLANK_EN is defined.
module bcd_convert_sequencer #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  RESETN,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [BW-1:0]        bcd_acc;
    logic [WIDTH-1:0]     bin_sh;
    logic                 ovf_acc;
    logic [CW-1:0]        cnt;

    logic [BW-1:0]        corr;
    logic [BW+WIDTH-1:0]  shifted;

    // Add-3 correction on every digit >= 5, then one left shift of the scratch pair.
    always_comb begin
        corr = bcd_acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_acc[4*k +: 4] >= 4'd5)
                corr[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
        end
        shifted = {corr[BW-2:0], bin_sh, 1'b0};
    end

`ifdef BCD_BLANK_EN
    function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
        logic lead;
        lead     = 1'b1;
        blank_lz = v;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && v[4*k +: 4] == 4'd0)
                blank_lz[4*k +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    endfunction
`endif

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            bcd_acc  <= '0;
            bin_sh   <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sh  <= bin_in;
                        bcd_acc <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_acc <= shifted[BW+WIDTH-1:WIDTH];
                    bin_sh  <= shifted[WIDTH-1:0];
                    // The top corrected bit is lost from the accumulator: that is overflow.
                    ovf_acc <= ovf_acc | corr[BW-1];
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
`ifdef BCD_BLANK_EN
                    bcd_out <= ovf_acc ? bcd_acc : blank_lz(bcd_acc);
`else
                    bcd_out <= bcd_acc;
`endif
                    overflow <= ovf_acc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Randomized scoreboard bench for bcd_convert_sequencer: a 3-digit and a 2-digit instance
// share stimulus; expected digits come from divide/modulo arithmetic.
module tb_bcd_convert_sequencer;

    localparam int W = 7;

    logic        CLOCK_50 = 1'b0;
    logic        RESETN;
    logic        start;
    logic [W-1:0] bin_in;
    logic        busy, done, overflow;
    logic [11:0] bcd_out;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd_out2;

    always #10 CLOCK_50 = ~CLOCK_50;

    bcd_convert_sequencer #(.WIDTH(W), .DIGITS(3)) u_dut (
        .CLOCK_50(CLOCK_50), .RESETN(RESETN), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow));

    bcd_convert_sequencer #(.WIDTH(W), .DIGITS(2)) u_dut2 (
        .CLOCK_50(CLOCK_50), .RESETN(RESETN), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2));

    typedef struct {
        logic [11:0] b3;
        logic        o3;
        logic [7:0]  b2;
        logic        o2;
        int          e;
        int          v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   next_free = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [19:0] ref_bcd(input int v, input int nd, output logic ovf);
        int m;
        int r;
        m = 1;
        for (int i = 0; i < nd; i++) m = m * 10;
        ovf = (v >= m);
        r = v % m;
        ref_bcd = '0;
        for (int i = 0; i < nd; i++) begin
            ref_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef BCD_BLANK_EN
        if (!ovf) begin
            int p;
            p = 10;
            for (int i = 1; i < nd; i++) begin
                if ((v % m) < p) ref_bcd[4*i +: 4] = 4'hF;
                p = p * 10;
            end
        end
`endif
    endfunction

    // Acceptance model: a start is taken when no conversion is in flight.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            cyc++;
            if (!RESETN) begin
                sb.delete();
                next_free = 0;
            end else if (start && cyc >= next_free) begin
                exp_t x;
                logic [19:0] t;
                t = ref_bcd(int'(bin_in), 3, x.o3);
                x.b3 = t[11:0];
                t = ref_bcd(int'(bin_in), 2, x.o2);
                x.b2 = t[7:0];
                x.e = cyc;
                x.v = int'(bin_in);
                sb.push_back(x);
                next_free = cyc + W + 2;
            end
        end
    end

    // Monitor: busy window check every cycle, result check on every done.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            checks++;
            if (busy !== (cyc + 2 <= next_free) || busy2 !== busy) begin
                errors++;
                $display("FAIL busy cyc=%0d: got %b/%b want %b", cyc, busy, busy2, (cyc + 2 <= next_free));
            end
            if (done || done2) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done cyc=%0d: done=%b done2=%b with nothing pending", cyc, done, done2);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    if (!(done && done2) || cyc != x.e + W + 1 ||
                        bcd_out !== x.b3 || overflow !== x.o3 ||
                        bcd_out2 !== x.b2 || overflow2 !== x.o2) begin
                        errors++;
                        $display("FAIL result v=%0d: got done=%b%b cyc=%0d bcd=%h ovf=%b bcd2=%h ovf2=%b want cyc=%0d bcd=%h ovf=%b bcd2=%h ovf2=%b",
                                 x.v, done, done2, cyc, bcd_out, overflow, bcd_out2, overflow2,
                                 x.e + W + 1, x.b3, x.o3, x.b2, x.o2);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK_50);
            if (sb.size() == 0 && !busy && !done) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: timeout with %0d pending, busy=%b", sb.size(), busy);
    endtask

    task automatic go(input int v);
        @(negedge CLOCK_50);
        start  = 1'b1;
        bin_in = W'(v);
        @(negedge CLOCK_50);
        start  = 1'b0;
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bcd"}, 32'(bcd_out), 32'h0);
        chk({tag, "_bcd2"}, 32'(bcd_out2), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        RESETN = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk_reset_outputs("reset");
        RESETN = 1'b1;

        go(127);
        go(0);
        go(99);

        // start pulse while busy must be ignored
        @(negedge CLOCK_50);
        start = 1'b1; bin_in = 7'd45;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        start = 1'b1; bin_in = 7'd100;
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_idle();
        go(100);

        // start held high, bin_in alternating per conversion
        @(negedge CLOCK_50);
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bin_in = (k % 2 == 0) ? 7'd5 : 7'd120;
            repeat (W + 2) @(negedge CLOCK_50);
        end
        start = 1'b0;
        wait_idle();

        // reset in the middle of a conversion
        @(negedge CLOCK_50);
        start = 1'b1; bin_in = 7'd77;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #1 RESETN = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge CLOCK_50);
        RESETN = 1'b1;
        go(64);

        // random starts, including pulses while busy
        for (int k = 0; k < 150; k++) begin
            @(negedge CLOCK_50);
            start  = ($urandom_range(0, 2) == 0);
            bin_in = W'($urandom_range(0, 127));
        end
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
